// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, least-significant digit first.
// Negative differences are turned into sign plus magnitude by a second serial 10's-complement pass.
module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  neg,
    output logic                  cout,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   idx_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    res_reg;
    logic            mode_reg;
    logic            carry_reg;
    logic            neg_reg;
    logic            cout_reg;
    logic            inv_reg;

    // Any nibble above 9 on either operand marks the request invalid.
    logic [2*DIGITS-1:0] bad_nib;
    logic                any_bad;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
        assign bad_nib[gi]          = (a[4*gi +: 4] > 4'd9);
        assign bad_nib[DIGITS + gi] = (b[4*gi +: 4] > 4'd9);
    end
    assign any_bad = |bad_nib;

    logic [3:0] a_dig;
    logic [3:0] b_dig;
    logic [3:0] r_dig;
    logic [3:0] op_x;
    logic [3:0] op_y;
    logic [4:0] z_sum;
    logic [4:0] z_adj;
    logic [3:0] dig_next;
    logic       carry_next;

    assign a_dig = a_reg[{idx_reg, 2'b00} +: 4];
    assign b_dig = b_reg[{idx_reg, 2'b00} +: 4];
    assign r_dig = res_reg[{idx_reg, 2'b00} +: 4];

    // One shared digit adder: A + (B or 9-B) while calculating, (9-R) + 0 while complementing.
    always_comb begin
        op_x = a_dig;
        op_y = b_dig;
        if (state_reg == S_FIX) begin
            op_x = 4'd9 - r_dig;
            op_y = 4'd0;
        end else if (mode_reg) begin
            op_y = 4'd9 - b_dig;
        end
    end

    assign z_sum      = {1'b0, op_x} + {1'b0, op_y} + {4'b0000, carry_reg};
    assign z_adj      = z_sum + 5'd6;
    assign carry_next = (z_sum > 5'd9);
    assign dig_next   = carry_next ? z_adj[3:0] : z_sum[3:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            mode_reg  <= 1'b0;
            carry_reg <= 1'b0;
            neg_reg   <= 1'b0;
            cout_reg  <= 1'b0;
            inv_reg   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            neg       <= 1'b0;
            cout      <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        mode_reg  <= mode;
                        idx_reg   <= '0;
                        carry_reg <= mode;
                        neg_reg   <= 1'b0;
                        cout_reg  <= 1'b0;
                        inv_reg   <= any_bad;
                        if (any_bad) begin
                            res_reg   <= '0;
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_CALC;
                        end
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_CALC: begin
                    res_reg[{idx_reg, 2'b00} +: 4] <= dig_next;
                    if (idx_reg == LAST_IDX) begin
                        idx_reg <= '0;
                        if (!mode_reg) begin
                            cout_reg  <= carry_next;
                            state_reg <= S_DONE;
                        end else if (carry_next) begin
                            state_reg <= S_DONE;
                        end else begin
                            // No end-around carry: A < B, so the stored digits are a 10's complement.
                            neg_reg   <= 1'b1;
                            carry_reg <= 1'b1;
                            state_reg <= S_FIX;
                        end
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        carry_reg <= carry_next;
                    end
                end
                S_FIX: begin
                    res_reg[{idx_reg, 2'b00} +: 4] <= dig_next;
                    if (idx_reg == LAST_IDX) begin
                        idx_reg   <= '0;
                        state_reg <= S_DONE;
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        carry_reg <= carry_next;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // Output bank is a registered copy of the internal state, one cycle behind it.
            busy    <= (state_reg == S_CALC) || (state_reg == S_FIX);
            done    <= (state_reg == S_DONE);
            result  <= res_reg;
            neg     <= neg_reg;
            cout    <= cout_reg;
            invalid <= inv_reg;
        end
    end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Random and directed stimulus for bcd_addsub_serial, checked against an integer-arithmetic model.
module tb_bcd_addsub_serial;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         neg;
    logic         cout;
    logic         invalid;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_addsub_serial #(.DIGITS(D)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .mode    (mode),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .neg     (neg),
        .cout    (cout),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic longint unsigned bcd2int(input logic [W-1:0] v);
        longint unsigned r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint unsigned v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && ($urandom_range(0, 7) == 0))
            r[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    // Wait for DONE, counting cycles after the acceptance edge and cycles with BUSY high.
    task automatic wait_done(input bit poke, output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (poke && n == 2) start = 1'b1;
            if (poke && n == 3) start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] er, output bit eng, output bit eco,
                         output bit einv, output int elat, output int ebusy);
        longint unsigned xv, yv, s, lim;
        lim = 1;
        for (int i = 0; i < D; i++) lim = lim * 10;
        einv = 0;
        for (int i = 0; i < D; i++)
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) einv = 1;
        xv = bcd2int(x);
        yv = bcd2int(y);
        eng = 0;
        eco = 0;
        if (einv) begin
            er = '0; elat = 1; ebusy = 0;
        end else if (!m) begin
            s = xv + yv;
            eco = (s >= lim);
            er = int2bcd(s % lim); elat = D + 1; ebusy = D;
        end else if (xv >= yv) begin
            er = int2bcd(xv - yv); elat = D + 1; ebusy = D;
        end else begin
            er = int2bcd(yv - xv); eng = 1; elat = 2 * D + 1; ebusy = 2 * D;
        end
    endtask

    task automatic check_result(input string tag, input logic m, input logic [W-1:0] x,
                                input logic [W-1:0] y, input int lat, input int nb);
        logic [W-1:0] er;
        bit eng, eco, einv;
        int elat, ebusy;
        model(m, x, y, er, eng, eco, einv, elat, ebusy);
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_result"}, 64'(result), 64'(er));
        chk({tag, "_neg"}, 64'(neg), 64'(eng));
        chk({tag, "_cout"}, 64'(cout), 64'(eco));
        chk({tag, "_invalid"}, 64'(invalid), 64'(einv));
        chk({tag, "_busy_cycles"}, 64'(nb), 64'(ebusy));
        $display("%s mode=%0d a=%h b=%h -> result=%h neg=%0d cout=%0d invalid=%0d latency=%0d",
                 tag, m, x, y, result, neg, cout, invalid, lat);
    endtask

    task automatic run_op(input string tag, input logic m, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit poke);
        int lat, nb;
        logic [W-1:0] held;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~m;
        a     = W'($urandom);
        b     = W'($urandom);
        wait_done(poke, lat, nb);
        check_result(tag, m, x, y, lat, nb);
        held = result;
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, 64'(result), 64'(held));
    endtask

    initial begin
        int lat, nb;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'({busy, done, neg, cout, invalid, result}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("add_basic", 1'b0, 16'h1234, 16'h5678, 1'b0);
        run_op("add_overflow", 1'b0, 16'h9999, 16'h0001, 1'b0);
        run_op("sub_pos", 1'b1, 16'h5000, 16'h1234, 1'b0);
        run_op("sub_zero", 1'b1, 16'h0042, 16'h0042, 1'b0);
        run_op("sub_neg_poke", 1'b1, 16'h0123, 16'h0456, 1'b1);
        run_op("add_invalid", 1'b0, 16'h00A0, 16'h0001, 1'b0);
        run_op("sub_invalid_b", 1'b1, 16'h0001, 16'hF000, 1'b0);

        // Reset asserted during the second calculation cycle aborts the operation.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 16'h1111; b = 16'h2222;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("reset_abort", 64'({busy, done, neg, cout, invalid, result}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_no_done", 64'(done), 64'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        run_op("after_reset", 1'b0, 16'h1111, 16'h2222, 1'b0);

        // START held high through DONE: second request is taken in the DONE state.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 16'h1234; b = 16'h5678;
        @(posedge clk);
        #1;
        mode = 1'b1; a = 16'h0123; b = 16'h0456;
        wait_done(1'b0, lat, nb);
        check_result("b2b_first", 1'b0, 16'h1234, 16'h5678, lat, nb);
        start = 1'b0;
        wait_done(1'b0, lat, nb);
        check_result("b2b_second", 1'b1, 16'h0123, 16'h0456, lat, nb);

        for (int t = 0; t < 40; t++) begin
            logic         rm;
            logic [W-1:0] rx, ry;
            rm = 1'($urandom_range(0, 1));
            rx = rand_bcd(1'b1);
            ry = rand_bcd(1'b1);
            run_op("random", rm, rx, ry, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_addsub_serial.md
Name: bcd_addsub_serial

Overview:
- Multi-digit BCD adder/subtractor. Processes one decimal digit per clock, least-significant digit first.
- Parametrised successor to the single-digit combinational BCD subtract path. Adds:
  - add and subtract modes
  - a signed result (sign plus magnitude) for subtraction
  - an add-overflow carry flag
  - detection of invalid input digits
  - a START/BUSY/DONE handshake
- Sits between the calculator's operand registers and the display driver.

Parameters:
- DIGITS, 4, number of BCD digits per operand/result (1..16); all data buses are 4*DIGITS bits.

Ports:
- CLK  input  1  rising-edge clock
- RESETN  input  1  asynchronous active-low reset
- START  input  1  request operation; sampled on rising CLK
- MODE  input  1  0 = A+B, 1 = A-B; sampled with START
- A  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
- B  input  4*DIGITS  operand B, packed BCD
- BUSY  output  1  operation in progress
- DONE  output  1  one-cycle pulse; results valid
- RESULT  output  4*DIGITS  packed BCD magnitude
- NEG  output  1  subtraction result is negative
- COUT  output  1  addition overflowed DIGITS digits
- INVALID  output  1  an input nibble was greater than 9

Behaviour:
- Reset (RESETN=0, asynchronous): state IDLE; BUSY, DONE, RESULT, NEG, COUT, INVALID all 0; internal registers cleared. Reset mid-operation aborts with no DONE.
- States: IDLE, CALC, FIX, DONE.
- Acceptance:
  - START=1 in IDLE or DONE captures A, B, MODE and the digit index is cleared.
  - NEG, COUT and INVALID clear on acceptance; RESULT holds its old value until overwritten.
  - START in CALC or FIX is ignored.
- Invalid digits:
  - If any nibble of A or B is >9 at acceptance, go directly to DONE.
  - RESULT=0, INVALID=1, NEG=0, COUT=0.
  - DONE pulses on the clock after acceptance.
- CALC: one cycle per digit i = 0..DIGITS-1.
  - Operand b_i = B digit (add) or 9's complement (9-B_i) (sub).
  - Initial carry is 0 (add) or 1 (sub).
  - Binary sum z = A_i + b_i + c.
  - If z > 9: digit = z+6 mod 16, carry = 1; else digit = z, carry = 0.
  - The digit is written to RESULT digit i and the carry is registered for the next digit.
- After digit DIGITS-1:
  - Add: COUT = final carry, go to DONE.
  - Sub with final carry 1: NEG=0, go to DONE. The carry is discarded.
  - Sub with final carry 0: NEG=1, go to FIX.
- FIX: DIGITS cycles.
  - Replaces RESULT with its 10's complement, computed serially.
  - Per digit: (9 - R_i) + c with initial c = 1, using the same BCD correction.
  - The final carry is discarded; then go to DONE.
- DONE: DONE=1 for exactly one cycle; next state is IDLE unless START=1.
- BUSY=1 in CALC and FIX only.
- Latency, counted from the sampling edge (k) of START:
  - DONE is high in the cycle following edge k+DIGITS+1 for add or non-negative subtract.
  - It follows edge k+2*DIGITS+1 for negative subtract.
  - It follows edge k+1 for invalid input.
- A and B may change after acceptance without effect.
- RESULT, NEG, COUT and INVALID hold until the next acceptance or reset.
- Zero results: A-A gives 0 with NEG=0 (final carry is 1). Negative zero cannot occur.

Test Plan:
- DIGITS=4, MODE=0, A=0x1234, B=0x5678 -> after 5 clocks: RESULT=0x6912, COUT=0, NEG=0, INVALID=0; BUSY high exactly 4 cycles; DONE a single-cycle pulse.
- MODE=0, A=0x9999, B=0x0001 -> RESULT=0x0000, COUT=1.
- MODE=1, A=0x5000, B=0x1234 -> RESULT=0x3766, NEG=0, DONE after 5 clocks. Then A=B=0x0042 -> RESULT=0x0000, NEG=0.
- MODE=1, A=0x0123, B=0x0456 -> FIX entered, RESULT=0x0333, NEG=1, DONE after 9 clocks. START pulsed during CALC is ignored and the result is unchanged.
- MODE=0, A=0x00A0, B=0x0001 -> DONE next cycle, INVALID=1, RESULT=0, BUSY never asserted.
- Start A=0x1111+B=0x2222 and assert RESETN=0 during the second CALC cycle -> all outputs 0 immediately, no DONE. After release, a new START computes 0x3333 normally. Back-to-back START held high through DONE is re-accepted in the DONE cycle.
